// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, FSM states, ALU/PC/RegDst codes.
// Build option MC_CTRL_JAL_EN enables the jr/jal decode; otherwise those opcodes are nops.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeLs = 3'b010,
        StMem   = 3'b011,
        StWbLd  = 3'b100,
        StExeBr = 3'b101,
        StExeAl = 3'b110,
        StWbAl  = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        ClsRAlu, ClsIAlu, ClsMem, ClsBranch, ClsJump, ClsHalt, ClsNop
    } op_class_e;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b010001;
    localparam logic [5:0] OpOr    = 6'b010011;
    localparam logic [5:0] OpSll   = 6'b011000;
    localparam logic [5:0] OpAddiu = 6'b000010;
    localparam logic [5:0] OpAndi  = 6'b010000;
    localparam logic [5:0] OpOri   = 6'b010010;
    localparam logic [5:0] OpSlti  = 6'b011100;
    localparam logic [5:0] OpSw    = 6'b100110;
    localparam logic [5:0] OpLw    = 6'b100111;
    localparam logic [5:0] OpBeq   = 6'b110000;
    localparam logic [5:0] OpBne   = 6'b110001;
    localparam logic [5:0] OpBltz  = 6'b110010;
    localparam logic [5:0] OpJ     = 6'b111000;
    localparam logic [5:0] OpJr    = 6'b111001;
    localparam logic [5:0] OpJal   = 6'b111010;
    localparam logic [5:0] OpHalt  = 6'b111111;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluSltu = 3'b010;
    localparam logic [2:0] AluSlt  = 3'b011;
    localparam logic [2:0] AluSll  = 3'b100;
    localparam logic [2:0] AluOr   = 3'b101;
    localparam logic [2:0] AluAnd  = 3'b110;
    localparam logic [2:0] AluXor  = 3'b111;

    localparam logic [1:0] PcSrcNext   = 2'b00;
    localparam logic [1:0] PcSrcBranch = 2'b01;
    localparam logic [1:0] PcSrcRs     = 2'b10;
    localparam logic [1:0] PcSrcJump   = 2'b11;

    localparam logic [1:0] RegDst31 = 2'b00;
    localparam logic [1:0] RegDstRt = 2'b01;
    localparam logic [1:0] RegDstRd = 2'b10;

    function automatic op_class_e op_class(logic [5:0] op);
        op_class_e cls;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpSll:  cls = ClsRAlu;
            OpAddiu, OpAndi, OpOri, OpSlti:    cls = ClsIAlu;
            OpSw, OpLw:                        cls = ClsMem;
            OpBeq, OpBne, OpBltz:              cls = ClsBranch;
            OpJ:                               cls = ClsJump;
`ifdef MC_CTRL_JAL_EN
            OpJr, OpJal:                       cls = ClsJump;
`endif
            OpHalt:                            cls = ClsHalt;
            default:                           cls = ClsNop;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit to datapath bundle: opcode/flags in, phase enables and selects out.
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [2:0] state;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic       DBDataSrc;
    logic       RegWre;
    logic       WrRegDSrc;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;

    modport master (
        input  opcode, zero, sign,
        output state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc
    );

    modport slave (
        output opcode, zero, sign,
        input  state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode from FSM state, opcode and ALU flags.
// jr/jal decoding depends on MC_CTRL_JAL_EN through mc_cpu_pkg::op_class.
module mc_ctrl_decode
    import mc_cpu_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       pc_wre,
    output logic       ir_wre,
    output logic       ins_mem_rw,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic [2:0] alu_op,
    output logic       m_rd,
    output logic       m_wr,
    output logic       db_data_src,
    output logic       reg_wre,
    output logic       wr_reg_d_src,
    output logic [1:0] reg_dst,
    output logic [1:0] pc_src
);
    op_class_e cls;
    logic      taken;

    always_comb begin
        cls          = op_class(opcode);
        taken        = 1'b0;
        pc_wre       = 1'b0;
        ir_wre       = 1'b0;
        ins_mem_rw   = 1'b1;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        ext_sel      = 1'b0;
        alu_op       = AluAdd;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        db_data_src  = 1'b0;
        reg_wre      = 1'b0;
        wr_reg_d_src = 1'b0;
        reg_dst      = RegDst31;
        pc_src       = PcSrcNext;

        // Opcode is not yet valid in IF, so datapath selects stay at their idle values there.
        if (state != StIf) begin
            case (opcode)
                OpSub:                alu_op = AluSub;
                OpAnd:                alu_op = AluAnd;
                OpOr:                 alu_op = AluOr;
                OpSll:                begin alu_op = AluSll; alu_src_a = 1'b1; end
                OpAddiu:              begin alu_src_b = 1'b1; ext_sel = 1'b1; end
                OpAndi:               begin alu_op = AluAnd; alu_src_b = 1'b1; end
                OpOri:                begin alu_op = AluOr; alu_src_b = 1'b1; end
                OpSlti:               begin alu_op = AluSlt; alu_src_b = 1'b1; ext_sel = 1'b1; end
                OpLw, OpSw:           begin alu_src_b = 1'b1; ext_sel = 1'b1; end
                OpBeq, OpBne, OpBltz: begin alu_op = AluSub; ext_sel = 1'b1; end
                default: ;
            endcase
        end

        unique case (state)
            StIf: ir_wre = 1'b1;
            StId: begin
                if (cls == ClsJump) begin
                    pc_wre = 1'b1;
                    pc_src = (opcode == OpJr) ? PcSrcRs : PcSrcJump;
                    if (opcode == OpJal) reg_wre = 1'b1;
                end else if (cls == ClsNop) begin
                    pc_wre = 1'b1;
                end
            end
            StExeBr: begin
                pc_wre = 1'b1;
                case (opcode)
                    OpBeq:   taken = zero;
                    OpBne:   taken = !zero;
                    OpBltz:  taken = sign;
                    default: taken = 1'b0;
                endcase
                if (taken) pc_src = PcSrcBranch;
            end
            StMem: begin
                m_rd   = (opcode == OpLw);
                m_wr   = (opcode == OpSw);
                pc_wre = (opcode == OpSw);
            end
            StWbLd: begin
                pc_wre       = 1'b1;
                reg_wre      = 1'b1;
                reg_dst      = RegDstRt;
                db_data_src  = 1'b1;
                wr_reg_d_src = 1'b1;
            end
            StWbAl: begin
                pc_wre       = 1'b1;
                reg_wre      = 1'b1;
                reg_dst      = (cls == ClsRAlu) ? RegDstRd : RegDstRt;
                wr_reg_d_src = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Five-phase multi-cycle CPU control: state register and next-state logic; outputs decoded
// combinationally in mc_ctrl_decode. MC_CTRL_JAL_EN enables jr/jal.
module multicycle_control_unit
    import mc_cpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
);
    state_e    state_q, state_d;
    op_class_e cls;

    always_comb begin
        cls     = op_class(bus.opcode);
        state_d = state_q;
        unique case (state_q)
            StIf: state_d = StId;
            StId: begin
                case (cls)
                    ClsRAlu, ClsIAlu: state_d = StExeAl;
                    ClsBranch:        state_d = StExeBr;
                    ClsMem:           state_d = StExeLs;
                    ClsHalt:          state_d = StId;
                    default:          state_d = StIf;
                endcase
            end
            StExeAl: state_d = StWbAl;
            StWbAl:  state_d = StIf;
            StExeBr: state_d = StIf;
            StExeLs: state_d = StMem;
            StMem:   state_d = (bus.opcode == OpLw) ? StWbLd : StIf;
            StWbLd:  state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIf;
        else        state_q <= state_d;
    end

    assign bus.state = state_q;

    mc_ctrl_decode u_decode (
        .state        (state_q),
        .opcode       (bus.opcode),
        .zero         (bus.zero),
        .sign         (bus.sign),
        .pc_wre       (bus.PCWre),
        .ir_wre       (bus.IRWre),
        .ins_mem_rw   (bus.InsMemRW),
        .alu_src_a    (bus.ALUSrcA),
        .alu_src_b    (bus.ALUSrcB),
        .ext_sel      (bus.ExtSel),
        .alu_op       (bus.ALUOp),
        .m_rd         (bus.mRD),
        .m_wr         (bus.mWR),
        .db_data_src  (bus.DBDataSrc),
        .reg_wre      (bus.RegWre),
        .wr_reg_d_src (bus.WrRegDSrc),
        .reg_dst      (bus.RegDst),
        .pc_src       (bus.PCSrc)
    );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; jal expectations follow
// MC_CTRL_JAL_EN.
module tb_multicycle_control_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.opcode = 6'b000000;
        bus.zero = 1'b0;
        bus.sign = 1'b0;
        #12;
        chk("rst_state", bus.state, 3'b000);
        chk("rst_irwre", bus.IRWre, 1'b1);
        chk("rst_pcwre", bus.PCWre, 1'b0);
        chk("rst_insmem", bus.InsMemRW, 1'b1);
        chk("rst_regwre", bus.RegWre, 1'b0);
        chk("rst_aluop", bus.ALUOp, 3'b000);
        chk("rst_pcsrc", bus.PCSrc, 2'b00);
        chk("rst_regdst", bus.RegDst, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // add: IF ID EXE_AL WB_AL IF
        tick(); chk("add_id", bus.state, 3'b001); chk("add_id_pcwre", bus.PCWre, 1'b0);
        chk("add_id_irwre", bus.IRWre, 1'b0);
        tick(); chk("add_exe", bus.state, 3'b110); chk("add_exe_regwre", bus.RegWre, 1'b0);
        chk("add_exe_srcb", bus.ALUSrcB, 1'b0);
        tick(); chk("add_wb", bus.state, 3'b111); chk("add_wb_regwre", bus.RegWre, 1'b1);
        chk("add_wb_pcwre", bus.PCWre, 1'b1); chk("add_wb_regdst", bus.RegDst, 2'b10);
        tick(); chk("add_if", bus.state, 3'b000);

        // lw
        bus.opcode = 6'b100111;
        tick(); chk("lw_id", bus.state, 3'b001);
        tick(); chk("lw_exe", bus.state, 3'b010); chk("lw_srcb", bus.ALUSrcB, 1'b1);
        chk("lw_ext", bus.ExtSel, 1'b1); chk("lw_aluop", bus.ALUOp, 3'b000);
        tick(); chk("lw_mem", bus.state, 3'b011); chk("lw_mrd", bus.mRD, 1'b1);
        chk("lw_mwr", bus.mWR, 1'b0); chk("lw_mem_pcwre", bus.PCWre, 1'b0);
        tick(); chk("lw_wb", bus.state, 3'b100); chk("lw_wb_regwre", bus.RegWre, 1'b1);
        chk("lw_wb_db", bus.DBDataSrc, 1'b1); chk("lw_wb_regdst", bus.RegDst, 2'b01);
        chk("lw_wb_pcwre", bus.PCWre, 1'b1);
        tick(); chk("lw_if", bus.state, 3'b000);

        // sw
        bus.opcode = 6'b100110;
        tick(); tick(); tick();
        chk("sw_mem", bus.state, 3'b011); chk("sw_mwr", bus.mWR, 1'b1);
        chk("sw_mrd", bus.mRD, 1'b0); chk("sw_pcwre", bus.PCWre, 1'b1);
        tick(); chk("sw_if", bus.state, 3'b000);

        // beq taken on zero
        bus.opcode = 6'b110000; bus.zero = 1'b1;
        tick(); chk("beq_id_pcwre", bus.PCWre, 1'b0);
        tick(); chk("beq_exe", bus.state, 3'b101); chk("beq_pcsrc", bus.PCSrc, 2'b01);
        chk("beq_pcwre", bus.PCWre, 1'b1); chk("beq_aluop", bus.ALUOp, 3'b001);
        tick(); chk("beq_if", bus.state, 3'b000);

        // bne not taken on zero
        bus.opcode = 6'b110001;
        tick(); tick(); chk("bne_pcsrc", bus.PCSrc, 2'b00); chk("bne_pcwre", bus.PCWre, 1'b1);
        tick();

        // bltz taken on sign
        bus.opcode = 6'b110010; bus.zero = 1'b0; bus.sign = 1'b1;
        tick(); tick(); chk("bltz_pcsrc", bus.PCSrc, 2'b01); chk("bltz_srcb", bus.ALUSrcB, 1'b0);
        tick(); bus.sign = 1'b0;

        // ori: zero-extended immediate, writes rt
        bus.opcode = 6'b010010;
        tick(); tick(); chk("ori_aluop", bus.ALUOp, 3'b101); chk("ori_srcb", bus.ALUSrcB, 1'b1);
        chk("ori_ext", bus.ExtSel, 1'b0);
        tick(); chk("ori_regdst", bus.RegDst, 2'b01);
        tick();

        // sll: shamt on A
        bus.opcode = 6'b011000;
        tick(); tick(); chk("sll_aluop", bus.ALUOp, 3'b100); chk("sll_srca", bus.ALUSrcA, 1'b1);
        tick(); tick();

        // slti
        bus.opcode = 6'b011100;
        tick(); tick(); chk("slti_aluop", bus.ALUOp, 3'b011); chk("slti_ext", bus.ExtSel, 1'b1);
        tick(); tick();

        // j
        bus.opcode = 6'b111000;
        tick(); chk("j_pcsrc", bus.PCSrc, 2'b11); chk("j_pcwre", bus.PCWre, 1'b1);
        chk("j_regwre", bus.RegWre, 1'b0);
        tick(); chk("j_if", bus.state, 3'b000);

        // jal
        bus.opcode = 6'b111010;
        tick(); chk("jal_pcwre", bus.PCWre, 1'b1);
`ifdef MC_CTRL_JAL_EN
        chk("jal_regwre", bus.RegWre, 1'b1); chk("jal_regdst", bus.RegDst, 2'b00);
        chk("jal_pcsrc", bus.PCSrc, 2'b11); chk("jal_wrsrc", bus.WrRegDSrc, 1'b0);
`else
        chk("jal_regwre", bus.RegWre, 1'b0); chk("jal_pcsrc", bus.PCSrc, 2'b00);
`endif
        tick(); chk("jal_if", bus.state, 3'b000);

        // unknown opcode behaves as nop
        bus.opcode = 6'b101010;
        tick(); chk("unk_pcwre", bus.PCWre, 1'b1); chk("unk_pcsrc", bus.PCSrc, 2'b00);
        chk("unk_regwre", bus.RegWre, 1'b0);
        tick(); chk("unk_if", bus.state, 3'b000);

        // async reset during MEM of sw
        bus.opcode = 6'b100110;
        tick(); tick(); tick();
        chk("swr_mwr_before", bus.mWR, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("swr_state", bus.state, 3'b000); chk("swr_mwr", bus.mWR, 1'b0);
        chk("swr_pcwre", bus.PCWre, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // halt holds in ID until reset
        bus.opcode = 6'b111111;
        tick(); chk("halt_id", bus.state, 3'b001);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold", bus.state, 3'b001);
            chk("halt_pcwre", bus.PCWre, 1'b0);
            chk("halt_irwre", bus.IRWre, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1 chk("halt_rst", bus.state, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.opcode = 6'b000000;
        tick(); chk("post_rst_id", bus.state, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
